// File: rtl/wb_dma_arb_pkg.sv
// Shared types and constants for the DMA channel arbiter.
package wb_dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/wb_dma_rr_pick.sv
// Find-first over a request vector, starting at a pointer and wrapping to 0.
module wb_dma_rr_pick #(
  parameter int unsigned N = 31,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  int unsigned base;
  int unsigned j;

  // Scan N positions from start, first set bit wins; out-of-range start behaves as 0.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    base  = 32'(start);
    j     = 0;
    if (base >= N) begin
      base = 0;
    end
    for (int unsigned k = 0; k < N; k++) begin
      j = base + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!found && req[W'(j)]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/wb_dma_ch_arb.sv
// Priority channel arbiter: registered max priority, then a held single-channel grant.
module wb_dma_ch_arb
  import wb_dma_arb_pkg::*;
#(
  parameter  int unsigned CH_COUNT   = 31,
  parameter  int unsigned PRI_LEVELS = 8,
  parameter  int unsigned ARB_MODE   = ARB_RR,
  localparam int unsigned PRI_W      = $clog2(PRI_LEVELS),
  localparam int unsigned CH_W       = $clog2(CH_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CH_COUNT-1:0]       valid,
  input  logic [CH_COUNT-1:0]       ch_en,
  input  logic [CH_COUNT*PRI_W-1:0] pri,
  input  logic                      ch_done,
  output logic                      gnt_vld,
  output logic [CH_W-1:0]           gnt_ch,
  output logic [PRI_W-1:0]          gnt_pri,
  output logic [PRI_W-1:0]          pri_out,
  output logic                      pri_any
);

  arb_state_e           state;
  logic [CH_COUNT-1:0]  elig;
  logic [CH_COUNT-1:0]  lvl_mask;
  logic [PRI_W-1:0]     pri_arr [CH_COUNT];
  logic [PRI_W-1:0]     pri_max;
  logic                 pri_hit;
  logic [CH_W-1:0]      rr_ptr [PRI_LEVELS];
  logic [CH_W-1:0]      rr_start;
  logic [CH_W-1:0]      rr_next;
  logic [CH_W-1:0]      pick_idx;
  logic                 pick_found;

  assign elig = valid & ch_en;

  // Unpack priorities and mark eligible channels sitting at the current top level.
  for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
    assign pri_arr[g]  = pri[g*PRI_W +: PRI_W];
    assign lvl_mask[g] = elig[g] && (pri_arr[g] == pri_out);
  end

  // Highest priority among eligible channels.
  always_comb begin
    pri_max = '0;
    pri_hit = 1'b0;
    for (int unsigned i = 0; i < CH_COUNT; i++) begin
      if (elig[i]) begin
        pri_hit = 1'b1;
        if (pri_arr[i] > pri_max) begin
          pri_max = pri_arr[i];
        end
      end
    end
  end

  // Search start: per-level pointer in round-robin mode, always 0 in fixed mode.
  always_comb begin
    rr_start = (ARB_MODE == ARB_RR) ? rr_ptr[pri_out] : '0;
    rr_next  = (gnt_ch == CH_W'(CH_COUNT - 1)) ? '0 : gnt_ch + CH_W'(1);
  end

  wb_dma_rr_pick #(
    .N (CH_COUNT),
    .W (CH_W)
  ) u_pick (
    .req   (lvl_mask),
    .start (rr_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Priority register, grant FSM and per-level round-robin pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_vld <= 1'b0;
      gnt_ch  <= '0;
      gnt_pri <= '0;
      pri_out <= '0;
      pri_any <= 1'b0;
      for (int unsigned l = 0; l < PRI_LEVELS; l++) begin
        rr_ptr[l] <= '0;
      end
    end else begin
      pri_out <= pri_max;
      pri_any <= pri_hit;
      case (state)
        IDLE: begin
          if (pri_any) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (pick_found) begin
            gnt_ch  <= pick_idx;
            gnt_pri <= pri_out;
            gnt_vld <= 1'b1;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          // Completion wins over a simultaneous valid drop.
          if (ch_done) begin
            rr_ptr[gnt_pri] <= rr_next;
            gnt_vld         <= 1'b0;
            state           <= IDLE;
          end else if (!valid[gnt_ch]) begin
            gnt_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          gnt_vld <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dma_ch_arb.sv
// Bench for wb_dma_ch_arb: fixed and round-robin instances checked against a behavioural model.
module tb_wb_dma_ch_arb;

  localparam int unsigned CH = 31;
  localparam int unsigned PL = 8;
  localparam int unsigned PW = 3;
  localparam int unsigned CW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [CH-1:0]    valid = '0;
  logic [CH-1:0]    ch_en = '0;
  logic [CH*PW-1:0] pri = '0;
  logic             ch_done = 1'b0;

  logic             d_vld  [2];
  logic [CW-1:0]    d_ch   [2];
  logic [PW-1:0]    d_gpri [2];
  logic [PW-1:0]    d_pout [2];
  logic             d_any  [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0 uses fixed lowest-index selection, instance 1 round-robin.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_dma_ch_arb #(
      .CH_COUNT   (CH),
      .PRI_LEVELS (PL),
      .ARB_MODE   (g)
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid),
      .ch_en   (ch_en),
      .pri     (pri),
      .ch_done (ch_done),
      .gnt_vld (d_vld[g]),
      .gnt_ch  (d_ch[g]),
      .gnt_pri (d_gpri[g]),
      .pri_out (d_pout[g]),
      .pri_any (d_any[g])
    );
  end

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s mode=%0d t=%0t got=%0d expected=%0d", nm, m, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_phase [2];          // 0 waiting, 1 choosing, 2 holding grant
  logic m_vld   [2];
  int   m_ch    [2];
  int   m_gpri  [2];
  int   m_ptr   [2][PL];
  int   m_pout;
  logic m_any;

  function automatic int pri_of(input int i);
    return int'(pri[i*PW +: PW]);
  endfunction

  function automatic bit is_elig(input int i);
    return valid[i] && ch_en[i];
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_phase[m] = 0; m_vld[m] = 1'b0; m_ch[m] = 0; m_gpri[m] = 0;
      for (int l = 0; l < PL; l++) m_ptr[m][l] = 0;
    end
    m_pout = 0;
    m_any  = 1'b0;
  end

  always @(posedge clk) begin : model
    int best;
    bit have;
    int pick;
    int j;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_phase[m] = 0; m_vld[m] = 1'b0; m_ch[m] = 0; m_gpri[m] = 0;
        for (int l = 0; l < PL; l++) m_ptr[m][l] = 0;
      end
      m_pout = 0;
      m_any  = 1'b0;
    end else begin
      best = 0;
      have = 1'b0;
      for (int i = 0; i < CH; i++) begin
        if (is_elig(i)) begin
          have = 1'b1;
          if (pri_of(i) > best) best = pri_of(i);
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (m_phase[m] == 0) begin
          if (m_any) m_phase[m] = 1;
        end else if (m_phase[m] == 1) begin
          pick = -1;
          for (int k = 0; k < CH; k++) begin
            j = (m == 1) ? (m_ptr[m][m_pout] + k) % CH : k;
            if (pick < 0 && is_elig(j) && pri_of(j) == m_pout) pick = j;
          end
          if (pick >= 0) begin
            m_ch[m] = pick; m_gpri[m] = m_pout; m_vld[m] = 1'b1; m_phase[m] = 2;
          end else begin
            m_phase[m] = 0;
          end
        end else begin
          if (ch_done) begin
            m_ptr[m][m_gpri[m]] = (m_ch[m] + 1) % CH;
            m_vld[m] = 1'b0; m_phase[m] = 0;
          end else if (!valid[m_ch[m]]) begin
            m_vld[m] = 1'b0; m_phase[m] = 0;
          end
        end
      end
      m_pout = best;
      m_any  = have;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("gnt_vld", m, 32'(d_vld[m]),  32'(m_vld[m]));
      chk("gnt_ch",  m, 32'(d_ch[m]),   32'(m_ch[m]));
      chk("gnt_pri", m, 32'(d_gpri[m]), 32'(m_gpri[m]));
      chk("pri_out", m, 32'(d_pout[m]), 32'(m_pout));
      chk("pri_any", m, 32'(d_any[m]),  32'(m_any));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_ch(input int i, input logic v, input int p);
    valid[i] = v;
    pri[i*PW +: PW] = PW'(p);
  endtask

  task automatic clear_all();
    valid = '0;
    pri   = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_done();
    @(negedge clk) ch_done = 1'b1;
    @(negedge clk) ch_done = 1'b0;
  endtask

  task automatic wait_grant(input int e_fix, input int e_rr);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #2;
      if (d_vld[0] && d_vld[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("grant_timeout", 2, 32'(seen), 32'd1);
    chk("lit_gnt_ch", 0, 32'(d_ch[0]), 32'(e_fix));
    chk("lit_gnt_ch", 1, 32'(d_ch[1]), 32'(e_rr));
  endtask

  initial begin
    // Reset held with every channel requesting.
    valid = '1;
    ch_en = '1;
    pri   = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int m = 0; m < 2; m++) begin
      chk("rst_gnt_vld", m, 32'(d_vld[m]), 32'd0);
      chk("rst_pri_any", m, 32'(d_any[m]), 32'd0);
      chk("rst_gnt_ch",  m, 32'(d_ch[m]),  32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("lat_c1_vld", 1, 32'(d_vld[1]), 32'd0);
    chk("lat_c1_any", 1, 32'(d_any[1]), 32'd1);
    @(posedge clk); #2;
    chk("lat_c2_vld", 1, 32'(d_vld[1]), 32'd0);
    @(posedge clk); #2;
    chk("lat_c3_vld", 1, 32'(d_vld[1]), 32'd1);
    chk("lat_c3_ch",  1, 32'(d_ch[1]),  32'd0);
    pulse_done();
    clear_all();

    // Two channels share the top level; a lower one never wins while they pend.
    set_ch(3, 1'b1, 2);
    set_ch(17, 1'b1, 6);
    set_ch(30, 1'b1, 6);
    @(posedge clk); #2;
    chk("lit_pri_out", 1, 32'(d_pout[1]), 32'd6);
    wait_grant(17, 17);
    chk("lit_gnt_pri", 1, 32'(d_gpri[1]), 32'd6);
    pulse_done();
    wait_grant(17, 30);
    pulse_done();
    wait_grant(17, 17);
    pulse_done();
    clear_all();

    // Pointer wraps from the last channel back to 0.
    set_ch(0, 1'b1, 7);
    set_ch(30, 1'b1, 7);
    wait_grant(0, 0);
    pulse_done();
    wait_grant(0, 30);
    pulse_done();
    wait_grant(0, 0);
    pulse_done();
    clear_all();

    // Abort: valid drops mid-grant, pointer must not move.
    set_ch(5, 1'b1, 4);
    set_ch(8, 1'b1, 4);
    wait_grant(5, 5);
    @(negedge clk) valid[5] = 1'b0;
    @(posedge clk); #2;
    chk("abort_vld", 0, 32'(d_vld[0]), 32'd0);
    chk("abort_vld", 1, 32'(d_vld[1]), 32'd0);
    @(negedge clk) valid[5] = 1'b1;
    wait_grant(5, 5);
    pulse_done();
    wait_grant(5, 8);
    pulse_done();
    clear_all();

    // Disabled high-priority channel is ignored; done with valid drop still advances.
    ch_en[9] = 1'b0;
    set_ch(9, 1'b1, 7);
    set_ch(2, 1'b1, 3);
    set_ch(12, 1'b1, 3);
    @(posedge clk); #2;
    chk("lit_pri_dis", 1, 32'(d_pout[1]), 32'd3);
    wait_grant(2, 2);
    @(negedge clk) begin ch_done = 1'b1; valid[2] = 1'b0; end
    @(negedge clk) begin ch_done = 1'b0; valid[2] = 1'b1; end
    wait_grant(2, 12);
    pulse_done();
    clear_all();

    // Done pulse while idle has no effect on later grants.
    pulse_done();
    repeat (2) @(negedge clk);
    ch_en[9] = 1'b1;
    set_ch(2, 1'b1, 3);
    set_ch(12, 1'b1, 3);
    wait_grant(2, 2);
    pulse_done();
    clear_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1);
  end

endmodule
